// File: rtl/de_pkg.sv
// Shared widths and state encoding for the drawing-engine memory arbiter.
package de_pkg;

  localparam int DE_ADDR_W  = 18;
  localparam int DE_NBYTE_W = 4;
  localparam int DE_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set req bit at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [2:0]   winner,
  output logic         valid
);

  logic [N-1:0] sh;

  // Walk offsets high to low so the smallest offset from ptr wins last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sh     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sh = req >> ((int'(ptr) + i) % N);
      if (sh[0]) begin
        winner = 3'((int'(ptr) + i) % N);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/de_arbiter.sv
// Arbitrates NREQ drawing engines onto one framebuffer port,
// one transaction at a time, round-robin.
module de_arbiter
  import de_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            de_req,
  output logic [NREQ-1:0]            de_ack,
  input  logic [NREQ*DE_ADDR_W-1:0]  de_addr,
  input  logic [NREQ*DE_NBYTE_W-1:0] de_nbyte,
  input  logic [NREQ-1:0]            de_rnw,
  input  logic [NREQ*DE_DATA_W-1:0]  de_w_data,
  output logic [DE_DATA_W-1:0]       de_r_data,
  output logic                       mem_req,
  input  logic                       mem_ack,
  output logic [DE_ADDR_W-1:0]       mem_addr,
  output logic [DE_NBYTE_W-1:0]      mem_nbyte,
  output logic                       mem_rnw,
  output logic [DE_DATA_W-1:0]       mem_w_data,
  input  logic [DE_DATA_W-1:0]       mem_r_data,
  output logic [2:0]                 grant_id,
  output logic                       busy
);

  state_t     state, state_nx;
  logic [2:0] rr_ptr;
  logic [2:0] win;
  logic       win_vld;
  logic [NREQ-1:0] rnw_sh;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  rr_pick #(.N(NREQ)) u_pick (
    .req    (de_req),
    .ptr    (rr_ptr),
    .winner (win),
    .valid  (win_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (win_vld) state_nx = ISSUE;
      ISSUE:   if (mem_ack) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state == ISSUE);
    busy    = (state != IDLE);
    de_ack  = (state == RESP) ? (ONE << grant_id) : '0;
  end

  assign rnw_sh = de_rnw >> win;

  // Request fields are latched once at grant; later engine changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      grant_id   <= '0;
      mem_addr   <= '0;
      mem_nbyte  <= '0;
      mem_rnw    <= 1'b1;
      mem_w_data <= '0;
      de_r_data  <= '0;
    end else begin
      if (state == IDLE && win_vld) begin
        grant_id   <= win;
        rr_ptr     <= (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
        mem_addr   <= DE_ADDR_W'(de_addr >> (int'(win) * DE_ADDR_W));
        mem_nbyte  <= DE_NBYTE_W'(de_nbyte >> (int'(win) * DE_NBYTE_W));
        mem_rnw    <= rnw_sh[0];
        mem_w_data <= DE_DATA_W'(de_w_data >> (int'(win) * DE_DATA_W));
      end
      if (state == ISSUE && mem_ack)
        de_r_data <= mem_r_data;
    end
  end

endmodule

// File: tb/tb_de_arbiter.sv
// Directed bench for de_arbiter: reset, round-robin, wait states, reset abort.
module tb_de_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   de_req;
  logic [3:0]   de_ack;
  logic [71:0]  de_addr;
  logic [15:0]  de_nbyte;
  logic [3:0]   de_rnw;
  logic [127:0] de_w_data;
  logic [31:0]  de_r_data;
  logic         mem_req;
  logic         mem_ack;
  logic [17:0]  mem_addr;
  logic [3:0]   mem_nbyte;
  logic         mem_rnw;
  logic [31:0]  mem_w_data;
  logic [31:0]  mem_r_data;
  logic [2:0]   grant_id;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  de_arbiter #(.NREQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .de_req     (de_req),
    .de_ack     (de_ack),
    .de_addr    (de_addr),
    .de_nbyte   (de_nbyte),
    .de_rnw     (de_rnw),
    .de_w_data  (de_w_data),
    .de_r_data  (de_r_data),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_nbyte  (mem_nbyte),
    .mem_rnw    (mem_rnw),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    de_req     = '0;
    de_addr    = '0;
    de_nbyte   = '0;
    de_rnw     = '0;
    de_w_data  = '0;
    mem_ack    = 1'b0;
    mem_r_data = '0;
    step; step;

    // reset values
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_rnw", mem_rnw, 1);
    chk("rst_de_ack", de_ack, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_r_data", de_r_data, 0);
    rst_n = 1'b1;

    // single write from engine 0, ack in first ISSUE cycle
    de_req           = 4'b0001;
    de_addr[17:0]    = 18'h00100;
    de_nbyte[3:0]    = 4'hF;
    de_rnw[0]        = 1'b0;
    de_w_data[31:0]  = 32'h1111_1111;
    mem_ack          = 1'b1;
    mem_r_data       = 32'h0BAD_0BAD;
    step;
    chk("w_mem_req", mem_req, 1);
    chk("w_mem_addr", mem_addr, 18'h00100);
    chk("w_mem_rnw", mem_rnw, 0);
    chk("w_mem_wdata", mem_w_data, 32'h1111_1111);
    chk("w_mem_nbyte", mem_nbyte, 4'hF);
    chk("w_ack_early", de_ack, 0);
    step;
    chk("w_de_ack", de_ack, 4'b0001);
    chk("w_mem_req_off", mem_req, 0);
    de_req  = 4'b0000;
    mem_ack = 1'b0;
    step;
    chk("w_idle_busy", busy, 0);
    chk("w_ack_gone", de_ack, 0);

    // fresh reset so the round-robin starts at engine 0
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      de_addr[i*18 +: 18] = 18'h00010 + 18'(i);
      de_rnw[i] = 1'b1;
    end
    de_req  = 4'b1111;
    mem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step;
      chk("rr_grant", grant_id, 64'(k % 4));
      chk("rr_addr", mem_addr, 64'(18'h00010 + 18'(k % 4)));
      step;
      chk("rr_ack", de_ack, 64'(4'b0001 << (k % 4)));
      step;
      chk("rr_ack_pulse", de_ack, 0);
    end
    de_req  = 4'b0000;
    mem_ack = 1'b0;
    step;

    // engine 2 read with five ISSUE cycles (pointer now at 1)
    de_req            = 4'b0100;
    de_addr[36 +: 18] = 18'h2ABCD;
    de_rnw[2]         = 1'b1;
    step;
    chk("rd_grant", grant_id, 2);
    for (int i = 0; i < 5; i++) begin
      chk("rd_mem_req", mem_req, 1);
      chk("rd_addr", mem_addr, 18'h2ABCD);
      if (i == 4) begin
        mem_ack    = 1'b1;
        mem_r_data = 32'hDEAD_BEEF;
      end
      step;
    end
    chk("rd_de_ack", de_ack, 4'b0100);
    chk("rd_r_data", de_r_data, 32'hDEAD_BEEF);
    de_req  = 4'b0000;
    mem_ack = 1'b0;
    step;

    // engine 1 alters its address mid-ISSUE
    de_req            = 4'b0010;
    de_addr[18 +: 18] = 18'h01111;
    de_rnw[1]         = 1'b0;
    step;
    chk("hold_addr0", mem_addr, 18'h01111);
    de_addr[18 +: 18] = 18'h3FFFF;
    step;
    chk("hold_addr1", mem_addr, 18'h01111);
    chk("hold_grant", grant_id, 1);
    mem_ack = 1'b1;
    step;
    chk("hold_ack", de_ack, 4'b0010);
    de_req  = 4'b0000;
    mem_ack = 1'b0;
    step;

    // reset in the middle of ISSUE for engine 3
    de_req = 4'b1000;
    step;
    chk("ab_mem_req", mem_req, 1);
    chk("ab_grant", grant_id, 3);
    rst_n = 1'b0;
    #1;
    chk("ab_req_drop", mem_req, 0);
    chk("ab_busy", busy, 0);
    chk("ab_no_ack", de_ack, 0);
    step;
    chk("ab_no_ack2", de_ack, 0);
    de_req = 4'b1001;
    rst_n  = 1'b1;
    step;
    chk("ab_next_grant", grant_id, 0);
    mem_ack = 1'b1;
    step;
    chk("ab_next_ack", de_ack, 4'b0001);
    de_req  = 4'b0000;
    mem_ack = 1'b1;
    step;

    // stray mem_ack while idle
    step; step;
    chk("stray_busy", busy, 0);
    chk("stray_ack", de_ack, 0);
    chk("stray_mem_req", mem_req, 0);
    mem_ack = 1'b0;
    step;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/de_arbiter.md
DE_ARBITER -- requirements
Module: de_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of drawing-engine requesters (2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port de_req, input, NREQ bits: per-engine memory request, held high until that engine's de_ack.
REQ-005 The block SHALL have port de_ack, output, NREQ bits: per-engine one-cycle completion pulse.
REQ-006 The block SHALL have port de_addr, input, NREQ*18 bits: packed word addresses; slice i belongs to engine i.
REQ-007 The block SHALL have port de_nbyte, input, NREQ*4 bits: packed byte-lane enables.
REQ-008 The block SHALL have port de_rnw, input, NREQ bits: 1 = read, 0 = write.
REQ-009 The block SHALL have port de_w_data, input, NREQ*32 bits: packed write data.
REQ-010 The block SHALL have port de_r_data, output, 32 bits: read data broadcast to all engines, valid while de_ack is high.
REQ-011 The block SHALL have ports mem_req (out, 1), mem_ack (in, 1), mem_addr (out, 18), mem_nbyte (out, 4), mem_rnw (out, 1), mem_w_data (out, 32) and mem_r_data (in, 32) forming the single shared framebuffer port.
REQ-012 The block SHALL have port grant_id, output, 3 bits: index of the engine currently being served.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 The state machine SHALL have three states: IDLE, ISSUE and RESP.
REQ-015 In IDLE with any de_req bit high, the block SHALL select one winner round-robin, starting the search at pointer rr_ptr and ascending modulo NREQ, and move to ISSUE.
REQ-016 On entering ISSUE, the block SHALL register the winner's addr, nbyte, rnw and w_data into the mem_* outputs; these SHALL stay stable throughout ISSUE.
REQ-017 In ISSUE, mem_req SHALL be high; on a cycle with mem_ack high, the block SHALL capture mem_r_data into de_r_data and move to RESP.
REQ-018 In RESP, de_ack[grant_id] SHALL be high for exactly one cycle and all other de_ack bits low; the next state SHALL be IDLE unconditionally.
REQ-019 When a grant is made, rr_ptr SHALL become (winner+1) mod NREQ.
REQ-020 An engine's de_req that is still high in the IDLE cycle immediately after its RESP SHALL be treated as a new request; engines drop de_req on the edge where they sample de_ack.
REQ-021 There SHALL be a minimum of 3 cycles per transaction (IDLE, ISSUE, RESP) with mem_ack in the first ISSUE cycle; there is no ISSUE timeout.
REQ-022 de_req changes during ISSUE or RESP SHALL NOT affect the current transaction.
REQ-023 For a write, de_r_data SHALL still be loaded from mem_r_data, and its value is don't-care.
REQ-024 mem_ack while not in ISSUE SHALL be ignored.
REQ-025 With a single requester, that requester SHALL be granted every transaction with no starvation penalty.

Reset
REQ-026 On rst_n low, the block SHALL immediately enter IDLE and set rr_ptr=0, grant_id=0, mem_req=0, de_ack=0, mem_addr=0, mem_nbyte=0, mem_rnw=1, mem_w_data=0, de_r_data=0 and busy=0.
REQ-027 Reset asserted mid-ISSUE SHALL drop mem_req without waiting for mem_ack, and the interrupted engine SHALL receive no de_ack.

Structure
REQ-028 Shared package de_pkg SHALL hold DE_ADDR_W=18, DE_NBYTE_W=4, DE_DATA_W=32 and the state encodings (IDLE=0, ISSUE=1, RESP=2).
REQ-029 The round-robin winner selection SHALL be one combinational sub-module, rr_pick (inputs req and ptr; outputs winner index and valid).

Verification
REQ-030 Reset then de_req=4'b0001 with addr0=18'h00100, rnw=0, wdata=32'h1111_1111 and mem_ack on the 1st ISSUE cycle -> mem_addr=18'h00100, then de_ack=4'b0001 one cycle later; total 3 cycles.
REQ-031 de_req=4'b1111 held continuously -> grants in order 0,1,2,3,0 with each de_ack a single pulse.
REQ-032 Read from engine 2 with mem_ack delayed 5 cycles and mem_r_data=32'hDEAD_BEEF -> mem_req high for 5 cycles, addr stable, de_r_data=32'hDEAD_BEEF while de_ack=4'b0100.
REQ-033 Engine 1 changes addr1 during ISSUE -> mem_addr unchanged.
REQ-034 rst_n pulsed low mid-ISSUE -> mem_req=0 in the same cycle, busy=0, no de_ack, and the next grant starts from engine 0.
REQ-035 Stray mem_ack in IDLE with no requests -> no state change and no de_ack.
